mmu_sequencer: RTL and testbench
================================

# mmu_sequencer

Top-level control FSM for the 2x2 matrix-multiply datapath. It accepts eight operand bytes from the host (four weights, then four inputs) and writes them into operand memory. It then drives the feeder's `en`/`mmu_cycle` through a fixed compute window and hands the four results back to the host, one byte per handshake, by stepping `output_sel`. It sits between the host byte interface, the operand memory and the feeder; result bytes themselves flow feeder → host and do not pass through this block.

## Interface
Parameters:
- `COMPUTE_CYCLES`, 7: length of the compute window in cycles; legal range 6–7, since `mmu_cycle` value 7 is reserved for readout.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `in_valid`  in  1  host operand byte valid.
- `in_data`  in  8  host operand byte.
- `in_ready`  out  1  block can accept an operand byte.
- `mem_we`  out  1  operand memory write strobe.
- `mem_addr`  out  3  operand address: 0–3 are weight0–3, 4–7 are input0–3.
- `mem_wdata`  out  8  operand write data; always equal to `in_data`.
- `feeder_en`  out  1  drives feeder `en`.
- `mmu_cycle`  out  3  drives feeder `mmu_cycle`.
- `output_sel`  out  2  drives feeder `output_sel`: 0=c00, 1=c01, 2=c10, 3=c11.
- `out_valid`  out  1  feeder `host_outdata` holds a valid result byte.
- `out_ready`  in  1  host consumes the result byte.
- `busy`  out  1  high in COMPUTE and READ.

## Operation
- States: LOAD, COMPUTE, READ. Reset state is LOAD.
- LOAD:
  - `in_ready`=1.
  - Accept is `in_valid && in_ready`.
  - On accept: `mem_we`=1 combinationally, `mem_addr`=`load_cnt`, then `load_cnt` increments.
  - On the accept with `load_cnt`==7: `load_cnt` wraps to 0 and the next state is COMPUTE.
  - Gaps in `in_valid` are allowed and leave `load_cnt` unchanged.
- COMPUTE:
  - `feeder_en`=1 and `in_ready`=0.
  - `mmu_cycle` starts at 0 and increments by 1 each cycle.
  - After the cycle with `mmu_cycle`==`COMPUTE_CYCLES`-1, the next state is READ.
  - `in_valid` is ignored and no memory write occurs.
- READ:
  - `feeder_en`=1 and `mmu_cycle`=3'b111, so the feeder injects zeros, keeps `clear` low and the accumulators hold.
  - `out_valid`=1 and `output_sel`=`rd_cnt`.
  - On `out_valid && out_ready`, `rd_cnt` increments.
  - When the accept happens with `rd_cnt`==3: `rd_cnt` returns to 0 and the next state is LOAD. `feeder_en` drops, so the feeder asserts `clear` on the following edge.
- `out_ready` is ignored outside READ.
- A new operand load cannot begin until all four results have been accepted. There is no partial readout or skip.
- Reset mid-operation (any state, any count) returns to LOAD with all counters at 0. Any partially loaded operands are discarded logically; the memory contents are not cleared.
- Operand and result arithmetic is outside this block. Counter widths: `load_cnt` is 3 bits, `rd_cnt` is 2 bits, the compute counter is 3 bits.

## Timing
- Values after any clock edge with `rst_n`=0:
  - `in_ready`=1, `mem_we`=0, `mem_addr`=0.
  - `feeder_en`=0, `mmu_cycle`=0, `output_sel`=0.
  - `out_valid`=0, `busy`=0.
- All outputs are registered state/counter values or simple decodes of them. The exception is `mem_we`, which depends combinationally on `in_valid`.
- LOAD→COMPUTE latency: `feeder_en` rises on the edge that accepts byte 7, so the first COMPUTE cycle is the next cycle.
- COMPUTE lasts exactly `COMPUTE_CYCLES` cycles. `out_valid` first rises in cycle `COMPUTE_CYCLES` after COMPUTE entry, counting the entry cycle as 0.
- With `out_ready` held at 1, READ lasts exactly 4 cycles and `output_sel` steps 0,1,2,3.
- `output_sel` is stable while `out_valid`=1 and `out_ready`=0.
- Best-case round trip with `COMPUTE_CYCLES`=7 is 8 load + 7 compute + 4 read = 19 cycles.

## Structure
- Shared package `tpu_pkg` holds:
  - the state enum `seq_state_t` {LOAD, COMPUTE, READ};
  - `NUM_OPERANDS`=8, `NUM_RESULTS`=4;
  - `MMU_CYCLE_IDLE`=3'b111;
  - the operand address constants `WEIGHT_BASE`=0 and `INPUT_BASE`=4.
- Single flat module; no sub-module. The counters are trivial and are kept inline.

## Test plan
- Reset then load bytes 1..8 with `in_valid` held high → `mem_addr` steps 0..7 with `mem_we`=1 each cycle; `feeder_en` rises the cycle after byte 8; `mmu_cycle` runs 0..6.
- Load with `in_valid` toggled 1,0,1,0… → exactly 8 writes at addresses 0..7; no duplicate or skipped address; `in_ready` stays 1 until byte 8.
- In READ with `out_ready`=0 for 5 cycles, then 1 → `out_valid`=1 and `output_sel`=0 held stable, then steps 0→1→2→3; the state then returns to LOAD with `feeder_en`=0.
- Drive `in_valid`=1 during COMPUTE and READ → `in_ready`=0 and `mem_we`=0 throughout.
- Assert `rst_n`=0 for one cycle after 5 bytes loaded, and again at `mmu_cycle`==3 → LOAD with `in_ready`=1 and `feeder_en`=0; the next accepted byte writes `mem_addr`=0.
- End-to-end with the feeder and array, weights {1,2,3,4} and inputs {5,6,7,8} → read bytes equal the low bytes of the reference 2x2 product, in order c00, c01, c10, c11.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply control path.
package tpu_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    READ    = 2'd2
  } seq_state_t;

  localparam int NUM_OPERANDS = 8;
  localparam int NUM_RESULTS  = 4;

  localparam logic [2:0] MMU_CYCLE_IDLE = 3'b111;

  localparam logic [2:0] WEIGHT_BASE = 3'd0;
  localparam logic [2:0] INPUT_BASE  = 3'd4;

endpackage

// File: rtl/mmu_sequencer.sv
// Control FSM: loads eight operand bytes, runs the fixed compute window,
// then walks output_sel across the four result bytes under host handshake.
module mmu_sequencer
  import tpu_pkg::*;
#(
  parameter int COMPUTE_CYCLES = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [2:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       feeder_en,
  output logic [2:0] mmu_cycle,
  output logic [1:0] output_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [2:0] LAST_OPERAND = 3'(NUM_OPERANDS - 1);
  localparam logic [2:0] LAST_CYCLE   = 3'(COMPUTE_CYCLES - 1);
  localparam logic [1:0] LAST_RESULT  = 2'(NUM_RESULTS - 1);

  seq_state_t state_reg;
  logic [2:0] load_cnt_reg;
  logic [2:0] cyc_cnt_reg;
  logic [1:0] rd_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= LOAD;
      load_cnt_reg <= 3'd0;
      cyc_cnt_reg  <= 3'd0;
      rd_cnt_reg   <= 2'd0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (in_valid) begin
            // The 3-bit counter wraps to 0 by itself after operand 7.
            load_cnt_reg <= load_cnt_reg + 3'd1;
            if (load_cnt_reg == LAST_OPERAND) begin
              state_reg   <= COMPUTE;
              cyc_cnt_reg <= 3'd0;
            end
          end
        end
        COMPUTE: begin
          if (cyc_cnt_reg == LAST_CYCLE) begin
            state_reg   <= READ;
            cyc_cnt_reg <= 3'd0;
            rd_cnt_reg  <= 2'd0;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 3'd1;
          end
        end
        READ: begin
          if (out_ready) begin
            rd_cnt_reg <= rd_cnt_reg + 2'd1;
            if (rd_cnt_reg == LAST_RESULT) begin
              state_reg <= LOAD;
            end
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  assign in_ready   = (state_reg == LOAD);
  assign mem_we     = in_ready && in_valid;
  assign mem_addr   = load_cnt_reg;
  assign mem_wdata  = in_data;
  assign feeder_en  = (state_reg == COMPUTE) || (state_reg == READ);
  assign busy       = feeder_en;
  assign out_valid  = (state_reg == READ);
  assign output_sel = rd_cnt_reg;

  // During readout the idle cycle code keeps the feeder injecting zeros.
  always_comb begin
    mmu_cycle = 3'd0;
    if (state_reg == COMPUTE) begin
      mmu_cycle = cyc_cnt_reg;
    end else if (state_reg == READ) begin
      mmu_cycle = MMU_CYCLE_IDLE;
    end
  end

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer with a phase-count reference model.
module tb_mmu_sequencer;

  localparam int CC = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       feeder_en;
  logic [2:0] mmu_cycle;
  logic [1:0] output_sel;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  mmu_sequencer #(.COMPUTE_CYCLES(CC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .feeder_en(feeder_en), .mmu_cycle(mmu_cycle),
    .output_sel(output_sel), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cycle, act, exp);
    end
  endtask

  // Reference model: progress counted as bytes loaded, compute cycles spent,
  // results consumed. The phase follows directly from those counts.
  int n_loaded = 0;
  int n_compute = 0;
  int n_read = 0;

  function automatic int phase();
    if (n_loaded < 8) return 0;
    if (n_compute < CC) return 1;
    return 2;
  endfunction

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!rst_n) begin
      n_loaded = 0; n_compute = 0; n_read = 0;
    end else begin
      case (phase())
        0: if (in_valid) n_loaded = n_loaded + 1;
        1: n_compute = n_compute + 1;
        default: if (out_ready) begin
          if (n_read == 3) begin
            n_loaded = 0; n_compute = 0; n_read = 0;
          end else begin
            n_read = n_read + 1;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      int p;
      p = phase();
      chk("in_ready", int'(in_ready), int'(p == 0));
      chk("mem_we", int'(mem_we), int'(p == 0 && in_valid));
      chk("mem_wdata", int'(mem_wdata), int'(in_data));
      if (p == 0) chk("mem_addr", int'(mem_addr), n_loaded);
      chk("feeder_en", int'(feeder_en), int'(p != 0));
      chk("busy", int'(busy), int'(p != 0));
      chk("mmu_cycle", int'(mmu_cycle), (p == 0) ? 0 : (p == 1) ? n_compute : 7);
      chk("out_valid", int'(out_valid), int'(p == 2));
      if (p == 2) chk("output_sel", int'(output_sel), n_read);
    end
  end

  // Write log taken from the memory-side strobes.
  logic [7:0] wr_mem [8];
  int wr_count = 0;
  int last_addr = -1;
  int last_data = -1;
  always @(posedge clk) begin
    if (rst_n && mem_we) begin
      wr_mem[mem_addr] <= mem_wdata;
      wr_count <= wr_count + 1;
      last_addr <= int'(mem_addr);
      last_data <= int'(mem_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] base, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      step();
      if (gaps && i != 7) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        chk("gap_in_ready", int'(in_ready), 1);
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_compute_read(input int stall);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int i = 0; i < CC; i++) step();
    chk("read_entry_out_valid", int'(out_valid), 1);
    chk("read_entry_mmu_cycle", int'(mmu_cycle), 7);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) step();
    chk("stall_output_sel", int'(output_sel), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("read_step_sel", int'(output_sel), i);
      step();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("back_to_load_feeder_en", int'(feeder_en), 0);
    chk("back_to_load_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int guard;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step();
    step();
    check_en = 1'b1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_feeder_en", int'(feeder_en), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_mem_addr", int'(mem_addr), 0);
    rst_n = 1'b1;

    // Back-to-back load of 1..8.
    load8(8'd1, 1'b0);
    chk("load_writes", wr_count, 8);
    for (int i = 0; i < 8; i++) chk("load_data", int'(wr_mem[i]), i + 1);
    chk("compute_entry_feeder_en", int'(feeder_en), 1);
    chk("compute_entry_mmu_cycle", int'(mmu_cycle), 0);
    run_compute_read(5);
    chk("no_write_in_compute_read", wr_count, 8);
    $display("txn 1: contiguous load, 5-cycle read stall done");

    // Load with in_valid toggling.
    load8(8'h10, 1'b1);
    chk("gap_load_writes", wr_count, 16);
    for (int i = 0; i < 8; i++) chk("gap_load_data", int'(wr_mem[i]), 16 + i);
    run_compute_read(0);
    $display("txn 2: gapped load, unstalled read done");

    // Reset after five bytes.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(i); step();
    end
    in_valid = 1'b0;
    chk("partial_last_addr", last_addr, 4);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mid_load_reset_in_ready", int'(in_ready), 1);
    in_valid = 1'b1; in_data = 8'h77; step(); in_valid = 1'b0;
    chk("after_reset_addr", last_addr, 0);
    chk("after_reset_data", last_data, 8'h77);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    $display("txn 3: reset during load done");

    // Reset in the middle of compute.
    load8(8'h40, 1'b0);
    guard = 0;
    while (mmu_cycle != 3'd3 && guard < 20) begin step(); guard++; end
    chk("reach_mmu_cycle3", int'(guard < 20), 1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mid_compute_reset_in_ready", int'(in_ready), 1);
    chk("mid_compute_reset_feeder_en", int'(feeder_en), 0);
    wc = wr_count;
    in_valid = 1'b1; in_data = 8'h99; step(); in_valid = 1'b0;
    chk("after_compute_reset_addr", last_addr, 0);
    chk("after_compute_reset_count", wr_count, wc + 1);
    $display("txn 4: reset during compute done");

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
